// File: rtl/move_scheduler.sv
// move_scheduler: turns held key levels and the game tick into a serialized move-command stream.
// Ports: clk, rst (sync, active-high); tick_game_i (60 Hz pulse); key_*_lvl_i (held keys);
// piece_spawned_i, lines_valid_i/lines_cleared_i, game_over_i (game events);
// cmd_valid_o/cmd_o/cmd_ready_i (command handshake); level_o, gravity_period_o (difficulty).
module move_scheduler #(
    parameter int DAS_FRAMES      = 16,
    parameter int ARR_FRAMES      = 6,
    parameter int SOFT_FRAMES     = 2,
    parameter int GRAVITY_BASE    = 48,
    parameter int GRAVITY_STEP    = 4,
    parameter int GRAVITY_MIN     = 4,
    parameter int LINES_PER_LEVEL = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_game_i,
    input  logic       key_left_lvl_i,
    input  logic       key_right_lvl_i,
    input  logic       key_down_lvl_i,
    input  logic       key_rotate_lvl_i,
    input  logic       key_drop_lvl_i,
    input  logic       piece_spawned_i,
    input  logic       lines_valid_i,
    input  logic [2:0] lines_cleared_i,
    input  logic       game_over_i,
    output logic       cmd_valid_o,
    output logic [2:0] cmd_o,
    input  logic       cmd_ready_i,
    output logic [4:0] level_o,
    output logic [7:0] gravity_period_o
);
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} das_e;
    localparam logic [2:0] C_DOWN = 3'd4, C_HARD = 3'd5, C_GRAV = 3'd6;
    das_e              st_q [2];
    das_e              st_d [2];
    logic [7:0]        cnt_q [2];
    logic [7:0]        cnt_d [2];
    logic [4:0]        keys, key_q, rise;
    logic [1:0]        mv_req, kill;
    logic [7:0]        soft_q, soft_d, grav_q, grav_d, period_q, period_d;
    logic              down_req, grav_req, load, frozen, frozen_q;
    logic [6:1]        pend_q, pend_d, set, clr;
    logic              valid_q, valid_d;
    logic [2:0]        cmd_q, cmd_d, sel;
    logic [4:0]        level_q, level_d, lines_q, lines_d, sum;
    logic signed [11:0] per_s;
    // key order: 0 left, 1 right, 2 down, 3 rotate, 4 drop
    assign keys   = {key_drop_lvl_i, key_rotate_lvl_i, key_down_lvl_i, key_right_lvl_i, key_left_lvl_i};
    assign rise   = keys & ~key_q;
    // last press wins; on a simultaneous press left keeps priority
    assign kill   = {rise[0], rise[1] & ~rise[0]};
    assign frozen = game_over_i | frozen_q;
    assign load   = ~valid_q | cmd_ready_i;
    assign sel    = pend_q[5] ? 3'd5 : pend_q[3] ? 3'd3 : pend_q[1] ? 3'd1 :
                    pend_q[2] ? 3'd2 : pend_q[4] ? 3'd4 : pend_q[6] ? 3'd6 : 3'd0;
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            st_d[d]   = st_q[d];
            cnt_d[d]  = cnt_q[d];
            mv_req[d] = 1'b0;
            if (!keys[d] || kill[d]) begin
                st_d[d]  = IDLE;
                cnt_d[d] = '0;
            end else if (rise[d]) begin
                st_d[d]   = DELAY;
                cnt_d[d]  = '0;
                mv_req[d] = 1'b1;
            end else if (tick_game_i && st_q[d] != IDLE) begin
                if (cnt_q[d] == 8'((st_q[d] == DELAY ? DAS_FRAMES : ARR_FRAMES) - 1)) begin
                    st_d[d]   = REPEAT;
                    cnt_d[d]  = '0;
                    mv_req[d] = 1'b1;
                end else begin
                    cnt_d[d] = cnt_q[d] + 8'd1;
                end
            end
        end
        soft_d   = soft_q;
        down_req = 1'b0;
        if (!keys[2]) begin
            soft_d = '0;
        end else if (rise[2]) begin
            soft_d   = '0;
            down_req = 1'b1;
        end else if (tick_game_i) begin
            down_req = soft_q == 8'(SOFT_FRAMES - 1);
            soft_d   = down_req ? 8'd0 : soft_q + 8'd1;
        end
        // >= rather than == so a period shortened by a level-up still fires
        grav_req = tick_game_i && (9'(grav_q) + 9'd1 >= 9'(period_q));
        grav_d   = tick_game_i ? (grav_req ? 8'd0 : grav_q + 8'd1) : grav_q;
        if (piece_spawned_i || (load && !frozen && (sel == C_DOWN || sel == C_GRAV)))
            grav_d = '0;
        set = frozen ? 6'd0 : {grav_req, rise[4], down_req, rise[3], mv_req};
        for (int i = 1; i <= 6; i++)
            clr[i] = load && (sel == 3'(i) || sel == C_HARD);
        // a same-cycle set overrides the grant clear
        pend_d  = (frozen || piece_spawned_i) ? 6'd0 : (pend_q & ~clr) | set;
        valid_d = valid_q;
        cmd_d   = cmd_q;
        if (frozen) begin
            valid_d = 1'b0;
            cmd_d   = '0;
        end else if (load) begin
            valid_d = !piece_spawned_i && sel != 3'd0;
            cmd_d   = piece_spawned_i ? 3'd0 : sel;
        end
        sum     = lines_q + 5'(lines_cleared_i);
        lines_d = lines_q;
        level_d = level_q;
        if (lines_valid_i && !frozen) begin
            lines_d = sum >= 5'(LINES_PER_LEVEL) ? sum - 5'(LINES_PER_LEVEL) : sum;
            level_d = (sum >= 5'(LINES_PER_LEVEL) && level_q != 5'd31) ? level_q + 5'd1 : level_q;
        end
        per_s    = 12'(GRAVITY_BASE) - 12'(level_q) * 12'(GRAVITY_STEP);
        period_d = per_s < $signed(12'(GRAVITY_MIN)) ? 8'(GRAVITY_MIN) : per_s[7:0];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                st_q[d]  <= IDLE;
                cnt_q[d] <= '0;
            end
            key_q    <= '0;
            soft_q   <= '0;
            grav_q   <= '0;
            pend_q   <= '0;
            valid_q  <= 1'b0;
            cmd_q    <= '0;
            frozen_q <= 1'b0;
            level_q  <= '0;
            lines_q  <= '0;
            period_q <= 8'(GRAVITY_BASE);
        end else begin
            for (int d = 0; d < 2; d++) begin
                st_q[d]  <= st_d[d];
                cnt_q[d] <= cnt_d[d];
            end
            key_q    <= keys;
            soft_q   <= soft_d;
            grav_q   <= grav_d;
            pend_q   <= pend_d;
            valid_q  <= valid_d;
            cmd_q    <= cmd_d;
            frozen_q <= frozen;
            level_q  <= level_d;
            lines_q  <= lines_d;
            period_q <= period_d;
        end
    end
    assign cmd_valid_o      = valid_q;
    assign cmd_o            = cmd_q;
    assign level_o          = level_q;
    assign gravity_period_o = period_q;
endmodule
